// File: rtl/store_bus_ctrl_if.sv
// Data-bus write channel between the MEM-stage store engine and memory.
interface store_bus_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        ack;

  modport master (output req, we, addr, sel, wdata, input ack);
  modport slave  (input req, we, addr, sel, wdata, output ack);
endinterface

// File: rtl/store_bus_ctrl.sv
// store_bus_ctrl: MEM-stage store engine; steers rt into big-endian byte lanes and runs a req/ack write.
// Optional macro STORE_LLSC_EN adds the LLbit and conditional SC (ll_set_i / ll_clr_i ports).
module store_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [7:0]       op_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      rt_i,
  input  logic             flush_i,
`ifdef STORE_LLSC_EN
  input  logic             ll_set_i,
  input  logic             ll_clr_i,
`endif
  store_bus_ctrl_if.master bus,
  output logic             stall_o,
  output logic             done_o,
  output logic             ades_o,
  output logic [31:0]      badvaddr_o,
  output logic             berr_o,
  output logic             sc_result_o
);

  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SWL_OP = 8'b1110_1010;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] EXE_SWR_OP = 8'b1110_1110;
  localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state;
  logic             r_req;
  logic [31:0]      r_addr;
  logic [3:0]       r_sel;
  logic [31:0]      r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_ades;
  logic [31:0]      r_badvaddr;
  logic             r_berr;
  logic             r_sc_result;

  logic [1:0]  w_a;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic        w_is_store;
  logic        w_misalign;
  logic        w_idle_req;
  logic        w_accept;
  logic        w_ades_evt;
  logic        w_timeout;
  logic        w_sc_fail;

  assign w_a = addr_i[1:0];

  // Lane steering: bit3 of sel is byte 0 (most significant byte of the word).
  always_comb begin
    w_sel      = 4'b0000;
    w_wdata    = 32'h0;
    w_is_store = 1'b1;
    w_misalign = 1'b0;
    case (op_i)
      EXE_SB_OP: begin
        w_sel   = 4'b1000 >> w_a;
        w_wdata = {4{rt_i[7:0]}};
      end
      EXE_SH_OP: begin
        w_sel      = w_a[1] ? 4'b0011 : 4'b1100;
        w_wdata    = {2{rt_i[15:0]}};
        w_misalign = w_a[0];
      end
      EXE_SW_OP, EXE_SC_OP: begin
        w_sel      = 4'b1111;
        w_wdata    = rt_i;
        w_misalign = |w_a;
      end
      EXE_SWL_OP: begin
        w_sel   = 4'b1111 >> w_a;
        w_wdata = rt_i >> {w_a, 3'b000};
      end
      EXE_SWR_OP: begin
        w_sel   = ~(4'b0111 >> w_a);
        w_wdata = rt_i << {~w_a, 3'b000};
      end
      default: w_is_store = 1'b0;
    endcase
  end

  assign w_idle_req = rst & (r_state == S_IDLE) & valid_i & w_is_store & ~flush_i;
  assign w_accept   = w_idle_req & ~w_misalign;
  assign w_ades_evt = w_idle_req & w_misalign;
  assign w_timeout  = (r_cnt == CNT_LIMIT);

`ifdef STORE_LLSC_EN
  logic r_llbit;

  assign w_sc_fail = (op_i == EXE_SC_OP) & ~r_llbit;

  // LLbit: an external clear wins over set; a successful SC consumes it at accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_llbit <= 1'b0;
    end else if (ll_clr_i) begin
      r_llbit <= 1'b0;
    end else if (ll_set_i) begin
      r_llbit <= 1'b1;
    end else if (w_accept && op_i == EXE_SC_OP) begin
      r_llbit <= 1'b0;
    end
  end
`else
  assign w_sc_fail = 1'b0;
`endif

  // Store FSM; flush is ignored once BUSY because the store is already committed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_addr      <= 32'h0;
      r_sel       <= 4'b0000;
      r_wdata     <= 32'h0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_ades      <= 1'b0;
      r_badvaddr  <= 32'h0;
      r_berr      <= 1'b0;
      r_sc_result <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_ades      <= 1'b0;
      r_berr      <= 1'b0;
      r_sc_result <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_sc_fail) begin
            r_done <= 1'b1;
          end else if (w_accept) begin
            r_state <= S_BUSY;
            r_req   <= 1'b1;
            r_addr  <= {addr_i[31:2], 2'b00};
            r_sel   <= w_sel;
            r_wdata <= w_wdata;
            r_cnt   <= '0;
          end else if (w_ades_evt) begin
            r_ades     <= 1'b1;
            r_badvaddr <= addr_i;
          end
        end
        S_BUSY: begin
          if (bus.ack) begin
            r_state     <= S_IDLE;
            r_req       <= 1'b0;
            r_done      <= 1'b1;
            r_sc_result <= 1'b1;
            r_cnt       <= '0;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_berr  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req   = r_req;
  assign bus.we    = r_req;
  assign bus.addr  = r_addr;
  assign bus.sel   = r_sel;
  assign bus.wdata = r_wdata;

  // Stall covers the accept cycle and every BUSY cycle that does not end the transfer.
  assign stall_o     = w_accept | ((r_state == S_BUSY) & ~bus.ack & ~w_timeout);
  assign done_o      = r_done;
  assign ades_o      = r_ades;
  assign badvaddr_o  = r_badvaddr;
  assign berr_o      = r_berr;
  assign sc_result_o = r_sc_result;

  a_done_berr_excl: assert property (@(posedge clk) disable iff (!rst) !(r_done && r_berr));

  a_busy_hold: assert property (@(posedge clk) disable iff (!rst)
    (r_state == S_BUSY && !bus.ack && !w_timeout) |=>
      (r_req && $stable(r_addr) && $stable(r_sel) && $stable(r_wdata)));

endmodule

// File: tb/tb_store_bus_ctrl.sv
// Self-checking bench for store_bus_ctrl: scoreboard of expected bus writes plus per-scenario checks.
module tb_store_bus_ctrl;

  localparam int unsigned TMO = 4;

  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SWL = 8'b1110_1010;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_SWR = 8'b1110_1110;
  localparam logic [7:0] OP_SC  = 8'b1111_1000;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [7:0]  op_i;
  logic [31:0] addr_i;
  logic [31:0] rt_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic        ades_o;
  logic [31:0] badvaddr_o;
  logic        berr_o;
  logic        sc_result_o;
`ifdef STORE_LLSC_EN
  logic        ll_set_i;
  logic        ll_clr_i;
`endif

  store_bus_ctrl_if bus();

  store_bus_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .op_i        (op_i),
    .addr_i      (addr_i),
    .rt_i        (rt_i),
    .flush_i     (flush_i),
`ifdef STORE_LLSC_EN
    .ll_set_i    (ll_set_i),
    .ll_clr_i    (ll_clr_i),
`endif
    .bus         (bus.master),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .ades_o      (ades_o),
    .badvaddr_o  (badvaddr_o),
    .berr_o      (berr_o),
    .sc_result_o (sc_result_o)
  );

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  bit   tb_ll  = 1'b0;

  int          res_req, res_stall, res_done, res_done_at, res_berr, res_berr_at, res_ades;
  logic [31:0] res_badv;
  logic        res_sc;
  bit          res_zero;

  function automatic bit tb_is_store(input logic [7:0] op);
    return op inside {OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR, OP_SC};
  endfunction

  function automatic bit tb_misaligned(input logic [7:0] op, input logic [1:0] a);
    return (op == OP_SH && a[0]) || ((op == OP_SW || op == OP_SC) && a != 2'b00);
  endfunction

  function automatic logic [35:0] tb_lane(input logic [7:0] op, input logic [1:0] a,
                                          input logic [31:0] rt);
    logic [3:0]  s;
    logic [31:0] d;
    s = 4'b0000;
    d = 32'h0;
    case (op)
      OP_SB: begin
        d = {4{rt[7:0]}};
        case (a)
          2'd0: s = 4'b1000;
          2'd1: s = 4'b0100;
          2'd2: s = 4'b0010;
          default: s = 4'b0001;
        endcase
      end
      OP_SH: begin
        d = {2{rt[15:0]}};
        s = (a == 2'd2) ? 4'b0011 : 4'b1100;
      end
      OP_SW, OP_SC: begin
        s = 4'b1111;
        d = rt;
      end
      OP_SWL: case (a)
        2'd0: begin s = 4'b1111; d = rt; end
        2'd1: begin s = 4'b0111; d = {8'h0, rt[31:8]}; end
        2'd2: begin s = 4'b0011; d = {16'h0, rt[31:16]}; end
        default: begin s = 4'b0001; d = {24'h0, rt[31:24]}; end
      endcase
      OP_SWR: case (a)
        2'd0: begin s = 4'b1000; d = {rt[7:0], 24'h0}; end
        2'd1: begin s = 4'b1100; d = {rt[15:0], 16'h0}; end
        2'd2: begin s = 4'b1110; d = {rt[23:0], 8'h0}; end
        default: begin s = 4'b1111; d = rt; end
      endcase
      default: ;
    endcase
    return {s, d};
  endfunction

  // Present one op for a cycle, then watch `win` cycles; ack is raised in busy cycle k (0 = never).
  task automatic run_store(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                           input bit flush, input int k, input int win, input int rst_at);
    logic [35:0] lane;
    bit          acc;
    bit          wr;
    exp_t        e;
    logic        prev_req;
    res_req = 0; res_stall = 0; res_done = 0; res_done_at = -1;
    res_berr = 0; res_berr_at = -1; res_ades = 0; res_badv = 32'h0; res_sc = 1'b0; res_zero = 1'b0;
    lane = tb_lane(op, addr[1:0], rt);
    acc  = tb_is_store(op) && !tb_misaligned(op, addr[1:0]) && !flush;
    wr   = acc;
`ifdef STORE_LLSC_EN
    if (acc && op == OP_SC) begin
      wr    = tb_ll;
      tb_ll = 1'b0;
    end
`endif
    if (wr) begin
      e.addr  = {addr[31:2], 2'b00};
      e.sel   = lane[35:32];
      e.wdata = lane[31:0];
      exp_q.push_back(e);
    end
    @(negedge clk);
    valid_i = 1'b1; op_i = op; addr_i = addr; rt_i = rt; flush_i = flush;
    #1;
    res_stall += int'(stall_o);
    prev_req = bus.req;
    for (int c = 0; c < win; c++) begin
      @(negedge clk);
      valid_i = 1'b0;
      flush_i = 1'b0;
      bus.ack = (c + 1 == k);
      rst     = (c != rst_at);
      if (c == rst_at) tb_ll = 1'b0;
      #1;
      if (bus.req && !prev_req) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_req: got addr=%h sel=%b wdata=%h, required no request",
                   bus.addr, bus.sel, bus.wdata);
        end else begin
          e = exp_q.pop_front();
          if ({bus.addr, bus.sel, bus.wdata} !== {e.addr, e.sel, e.wdata}) begin
            n_fail++;
            $display("FAIL sb_write: got addr=%h sel=%b wdata=%h, required addr=%h sel=%b wdata=%h",
                     bus.addr, bus.sel, bus.wdata, e.addr, e.sel, e.wdata);
          end
        end
      end
      prev_req   = bus.req;
      res_req   += int'(bus.req);
      res_stall += int'(stall_o);
      if (done_o) begin res_done++; res_done_at = c; res_sc = sc_result_o; end
      if (berr_o) begin res_berr++; res_berr_at = c; end
      if (ades_o) begin res_ades++; res_badv = badvaddr_o; end
      if (rst_at >= 0 && c == rst_at + 1)
        res_zero = ({bus.req, bus.we, bus.addr, bus.sel, bus.wdata, stall_o, done_o, ades_o,
                     berr_o, sc_result_o, badvaddr_o} == '0);
    end
    bus.ack = 1'b0;
    rst     = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; valid_i = 1'b0; op_i = 8'h0; addr_i = 32'h0; rt_i = 32'h0; flush_i = 1'b0;
    bus.ack = 1'b0;
`ifdef STORE_LLSC_EN
    ll_set_i = 1'b0; ll_clr_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.req, bus.we, bus.addr, bus.sel, bus.wdata, done_o, ades_o, berr_o, sc_result_o,
         badvaddr_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b addr=%h sel=%b wdata=%h done=%b ades=%b berr=%b badv=%h, required all 0",
               bus.req, bus.addr, bus.sel, bus.wdata, done_o, ades_o, berr_o, badvaddr_o);
    end
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b, required 0", stall_o);
    end
    rst = 1'b1;
  endtask

  task automatic test_sb();
    run_store(OP_SB, 32'h0000_1003, 32'h0000_00A5, 1'b0, 2, 5, -1);
    n_cmp++;
    if (res_stall !== 2) begin n_fail++; $display("FAIL sb_stall: got %0d, required 2", res_stall); end
    n_cmp++;
    if (res_req !== 2) begin n_fail++; $display("FAIL sb_req_cycles: got %0d, required 2", res_req); end
    n_cmp++;
    if (res_done !== 1 || res_done_at !== 2) begin
      n_fail++; $display("FAIL sb_done: got count=%0d at=%0d, required count=1 at=2", res_done, res_done_at);
    end
  endtask

  task automatic test_lanes();
    logic [7:0]  ops[9]   = '{OP_SWL, OP_SWR, OP_SH, OP_SH, OP_SB, OP_SW, OP_SWL, OP_SWR, OP_SWR};
    logic [31:0] addrs[9] = '{32'h2001, 32'h2001, 32'h4000, 32'h4002, 32'h1001, 32'h3000,
                              32'h2003, 32'h2002, 32'h2003};
    for (int i = 0; i < 9; i++) begin
      run_store(ops[i], addrs[i], 32'h1122_3344, 1'b0, 1, 3, -1);
      n_cmp++;
      if (res_done !== 1 || res_done_at !== 1 || res_req !== 1) begin
        n_fail++;
        $display("FAIL lane_done[%0d]: got done=%0d at=%0d req=%0d, required done=1 at=1 req=1",
                 i, res_done, res_done_at, res_req);
      end
    end
  endtask

  task automatic test_misaligned();
    run_store(OP_SW, 32'h0000_3002, 32'hDEAD_BEEF, 1'b0, 0, 3, -1);
    n_cmp++;
    if (res_ades !== 1 || res_badv !== 32'h0000_3002) begin
      n_fail++; $display("FAIL ades_sw: got ades=%0d badv=%h, required 1 and 00003002", res_ades, res_badv);
    end
    n_cmp++;
    if (res_req !== 0 || res_done !== 0 || res_stall !== 0) begin
      n_fail++; $display("FAIL ades_sw_quiet: got req=%0d done=%0d stall=%0d, required 0/0/0",
                         res_req, res_done, res_stall);
    end
    run_store(OP_SH, 32'h0000_4001, 32'h0, 1'b0, 0, 3, -1);
    n_cmp++;
    if (res_ades !== 1 || res_badv !== 32'h0000_4001) begin
      n_fail++; $display("FAIL ades_sh: got ades=%0d badv=%h, required 1 and 00004001", res_ades, res_badv);
    end
    run_store(OP_SW, 32'h0000_3006, 32'h0, 1'b1, 0, 3, -1);
    n_cmp++;
    if (res_ades !== 0 || res_req !== 0 || badvaddr_o !== 32'h0000_4001) begin
      n_fail++; $display("FAIL ades_flush: got ades=%0d req=%0d badv=%h, required 0/0/00004001",
                         res_ades, res_req, badvaddr_o);
    end
    run_store(OP_SW, 32'h0000_3008, 32'h0, 1'b1, 1, 3, -1);
    n_cmp++;
    if (res_req !== 0 || res_done !== 0) begin
      n_fail++; $display("FAIL flush_aligned: got req=%0d done=%0d, required 0/0", res_req, res_done);
    end
    run_store(8'h21, 32'h0000_3001, 32'h0, 1'b0, 1, 3, -1);
    n_cmp++;
    if (res_req !== 0 || res_ades !== 0 || res_done !== 0) begin
      n_fail++; $display("FAIL non_store_op: got req=%0d ades=%0d done=%0d, required 0/0/0",
                         res_req, res_ades, res_done);
    end
  endtask

  task automatic test_timeout();
    run_store(OP_SH, 32'h0000_4000, 32'h0000_BEEF, 1'b0, 0, 8, -1);
    n_cmp++;
    if (res_req !== int'(TMO)) begin
      n_fail++; $display("FAIL tmo_req_cycles: got %0d, required %0d", res_req, TMO);
    end
    n_cmp++;
    if (res_berr !== 1 || res_berr_at !== int'(TMO) || res_done !== 0) begin
      n_fail++; $display("FAIL tmo_berr: got berr=%0d at=%0d done=%0d, required berr=1 at=%0d done=0",
                         res_berr, res_berr_at, res_done, TMO);
    end
    run_store(OP_SW, 32'h0000_4004, 32'h0BAD_F00D, 1'b0, int'(TMO), 8, -1);
    n_cmp++;
    if (res_done !== 1 || res_done_at !== int'(TMO) || res_berr !== 0) begin
      n_fail++; $display("FAIL ack_at_limit: got done=%0d at=%0d berr=%0d, required done=1 at=%0d berr=0",
                         res_done, res_done_at, res_berr, TMO);
    end
  endtask

  task automatic test_reset_busy();
    run_store(OP_SW, 32'h0000_6000, 32'h5555_AAAA, 1'b0, 0, 4, 1);
    n_cmp++;
    if (res_zero !== 1'b1 || res_req !== 2 || res_done !== 0) begin
      n_fail++; $display("FAIL reset_busy: got zero=%b req=%0d done=%0d, required zero=1 req=2 done=0",
                         res_zero, res_req, res_done);
    end
    run_store(OP_SW, 32'h0000_6004, 32'h1234_5678, 1'b0, 3, 6, -1);
    n_cmp++;
    if (res_done !== 1 || res_done_at !== 3 || res_req !== 3) begin
      n_fail++; $display("FAIL after_reset_sw: got done=%0d at=%0d req=%0d, required 1 at 3 req 3",
                         res_done, res_done_at, res_req);
    end
  endtask

  task automatic test_back_to_back();
    run_store(OP_SW, 32'h0000_7000, 32'hA0A0_A0A0, 1'b0, 1, 2, -1);
    run_store(OP_SB, 32'h0000_7002, 32'h0000_007E, 1'b0, 1, 3, -1);
    n_cmp++;
    if (res_done !== 1 || res_done_at !== 1 || res_stall !== 1) begin
      n_fail++; $display("FAIL back_to_back: got done=%0d at=%0d stall=%0d, required 1 at 1 stall 1",
                         res_done, res_done_at, res_stall);
    end
  endtask

  task automatic test_sc();
`ifdef STORE_LLSC_EN
    @(negedge clk); ll_set_i = 1'b1; tb_ll = 1'b1;
    @(negedge clk); ll_set_i = 1'b0;
`endif
    run_store(OP_SC, 32'h0000_5000, 32'hCAFE_F00D, 1'b0, 1, 3, -1);
    n_cmp++;
    if (res_req !== 1 || res_done !== 1 || res_sc !== 1'b1) begin
      n_fail++; $display("FAIL sc_write: got req=%0d done=%0d sc=%b, required 1/1/1", res_req, res_done, res_sc);
    end
`ifdef STORE_LLSC_EN
    run_store(OP_SC, 32'h0000_5004, 32'h1111_2222, 1'b0, 1, 3, -1);
    n_cmp++;
    if (res_req !== 0 || res_done !== 1 || res_done_at !== 0 || res_sc !== 1'b0) begin
      n_fail++; $display("FAIL sc_fail: got req=%0d done=%0d at=%0d sc=%b, required 0/1/0/0",
                         res_req, res_done, res_done_at, res_sc);
    end
    @(negedge clk); ll_set_i = 1'b1;
    @(negedge clk); ll_set_i = 1'b0; ll_clr_i = 1'b1;
    @(negedge clk); ll_clr_i = 1'b0; tb_ll = 1'b0;
    run_store(OP_SC, 32'h0000_5008, 32'h3333_4444, 1'b0, 1, 3, -1);
    n_cmp++;
    if (res_req !== 0 || res_sc !== 1'b0) begin
      n_fail++; $display("FAIL sc_after_clr: got req=%0d sc=%b, required 0/0", res_req, res_sc);
    end
`endif
  endtask

  task automatic test_drained();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL sb_drained: got %0d pending writes, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_lanes();
    test_misaligned();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    test_sc();
    test_drained();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end

endmodule
